// File: rtl/placement_cost_eval.sv
// placement_cost_eval
// Walks an edge list of a grid placement and accumulates wirelength figures.
// For each edge it reads both endpoint node ids from the edge ROM and then
// both endpoint coordinates from the position RAMs, all with synchronous reads.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   start, num_edges      launch handshake; num_edges latched when start is taken
//   edge_rd, edge_addr    edge ROM read port   (edge_a / edge_b return data)
//   pos_rd, pos_addr      position RAM read port (pos_x / pos_y return data)
//   busy, done            evaluation in progress / one-cycle completion pulse
//   cost_total, cost_hop  saturating sums of per-edge wirelength and hop cost
//   cost_max              largest per-edge wirelength
//   err_unplaced          edges skipped because an endpoint is unplaced (-1)
//   ev_cycles             cycles from the start-sampling edge to done
module placement_cost_eval #(
    parameter int COORD_W  = 8,
    parameter int NODE_AW  = 7,
    parameter int EDGE_AW  = 8,
    parameter int SUM_W    = 32,
    parameter int HOP_LOG2 = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [EDGE_AW:0]     num_edges,
    output logic                 edge_rd,
    output logic [EDGE_AW-1:0]   edge_addr,
    input  logic [NODE_AW-1:0]   edge_a,
    input  logic [NODE_AW-1:0]   edge_b,
    output logic                 pos_rd,
    output logic [NODE_AW-1:0]   pos_addr,
    input  logic [COORD_W-1:0]   pos_x,
    input  logic [COORD_W-1:0]   pos_y,
    output logic                 busy,
    output logic                 done,
    output logic [SUM_W-1:0]     cost_total,
    output logic [SUM_W-1:0]     cost_hop,
    output logic [COORD_W+1:0]   cost_max,
    output logic [EDGE_AW:0]     err_unplaced,
    output logic [31:0]          ev_cycles
);

    typedef enum logic [3:0] {
        S_IDLE, S_E_ISS, S_E_WT, S_A_ISS, S_A_WT, S_B_ISS,
        S_B_WT, S_B_CAP, S_DIFF, S_ACC, S_FIN
    } state_t;

    // Adder width wide enough for either operand plus a carry, so saturation
    // is detected even when SUM_W is narrower than a single edge cost.
    localparam int AW = ((SUM_W > COORD_W + 2) ? SUM_W : COORD_W + 2) + 1;
    localparam logic [COORD_W-1:0] UNPLACED = {COORD_W{1'b1}};
    localparam logic [COORD_W+1:0] ONE_W    = {{(COORD_W+1){1'b0}}, 1'b1};

    state_t               state_r, state_s;
    logic [EDGE_AW:0]     n_edges_r;
    logic [NODE_AW-1:0]   eb_r;
    logic [COORD_W-1:0]   xa_r, ya_r, xb_r, yb_r;
    logic [COORD_W:0]     dx_r, dy_r;
    logic                 unpl_r;
    logic                 last_s;
    logic [COORD_W+1:0]   sum_s, hsum_s, w_s, h_s;

    // |a-b| of two signed coordinates, computed one bit wider so it cannot overflow.
    function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        logic [COORD_W:0] d;
        d = {a[COORD_W-1], a} - {b[COORD_W-1], b};
        if (d[COORD_W]) begin
            abs_diff = ~d + {{COORD_W{1'b0}}, 1'b1};
        end else begin
            abs_diff = d;
        end
    endfunction

    // ceil(v / 2^HOP_LOG2): shift, then round up if any dropped bit was set.
    function automatic logic [COORD_W:0] ceil_shift(input logic [COORD_W:0] v);
        logic [COORD_W:0] mask;
        mask       = (COORD_W+1)'((1 << HOP_LOG2) - 1);
        ceil_shift = (v >> HOP_LOG2) + {{COORD_W{1'b0}}, |(v & mask)};
    endfunction

    // Saturating accumulate: clamps at all-ones instead of wrapping.
    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] acc,
                                                 input logic [COORD_W+1:0] inc);
        logic [AW-1:0] ext;
        ext = AW'(acc) + AW'(inc);
        if (ext > AW'({SUM_W{1'b1}})) begin
            sat_add = {SUM_W{1'b1}};
        end else begin
            sat_add = ext[SUM_W-1:0];
        end
    endfunction

    // Per-edge wirelength and hop cost from the registered deltas, plus end-of-list test.
    always_comb begin
        sum_s  = {1'b0, dx_r} + {1'b0, dy_r};
        hsum_s = {1'b0, ceil_shift(dx_r)} + {1'b0, ceil_shift(dy_r)};
        if (sum_s == '0) begin
            w_s = '0;
        end else begin
            w_s = sum_s - ONE_W;
        end
        if (hsum_s == '0) begin
            h_s = '0;
        end else begin
            h_s = hsum_s - ONE_W;
        end
        last_s = (({1'b0, edge_addr} + {{EDGE_AW{1'b0}}, 1'b1}) == n_edges_r);
    end

    // Next-state logic: a fixed nine-state walk per edge.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start && (num_edges == '0)) begin
                    state_s = S_FIN;
                end else if (start) begin
                    state_s = S_E_ISS;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_E_ISS: state_s = S_E_WT;
            S_E_WT:  state_s = S_A_ISS;
            S_A_ISS: state_s = S_A_WT;
            S_A_WT:  state_s = S_B_ISS;
            S_B_ISS: state_s = S_B_WT;
            S_B_WT:  state_s = S_B_CAP;
            S_B_CAP: state_s = S_DIFF;
            S_DIFF:  state_s = S_ACC;
            S_ACC: begin
                if (last_s) begin
                    state_s = S_FIN;
                end else begin
                    state_s = S_E_ISS;
                end
            end
            S_FIN:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= S_IDLE;
            n_edges_r    <= '0;
            eb_r         <= '0;
            xa_r         <= '0;
            ya_r         <= '0;
            xb_r         <= '0;
            yb_r         <= '0;
            dx_r         <= '0;
            dy_r         <= '0;
            unpl_r       <= 1'b0;
            edge_rd      <= 1'b0;
            edge_addr    <= '0;
            pos_rd       <= 1'b0;
            pos_addr     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cost_total   <= '0;
            cost_hop     <= '0;
            cost_max     <= '0;
            err_unplaced <= '0;
            ev_cycles    <= '0;
        end else begin
            state_r <= state_s;
            // Read strobes are asserted for exactly the cycle spent in the issue states.
            edge_rd <= (state_s == S_E_ISS);
            pos_rd  <= (state_s == S_A_ISS) || (state_s == S_B_ISS);
            busy    <= (state_s != S_IDLE) && (state_s != S_FIN);
            done    <= (state_r == S_FIN);
            // Edge ROM data is already valid in E_WT, so the A address is loaded from it directly.
            if (state_s == S_A_ISS) begin
                pos_addr <= edge_a;
            end else if (state_s == S_B_ISS) begin
                pos_addr <= eb_r;
            end else begin
                pos_addr <= pos_addr;
            end
            if ((state_r == S_IDLE) && start) begin
                ev_cycles <= '0;
            end else if (state_r != S_IDLE) begin
                ev_cycles <= ev_cycles + 32'd1;
            end else begin
                ev_cycles <= ev_cycles;
            end
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        n_edges_r    <= num_edges;
                        edge_addr    <= '0;
                        cost_total   <= '0;
                        cost_hop     <= '0;
                        cost_max     <= '0;
                        err_unplaced <= '0;
                    end
                end
                S_A_ISS: eb_r <= edge_b;
                S_B_ISS: begin
                    xa_r <= pos_x;
                    ya_r <= pos_y;
                end
                S_B_CAP: begin
                    xb_r <= pos_x;
                    yb_r <= pos_y;
                end
                S_DIFF: begin
                    dx_r   <= abs_diff(xa_r, xb_r);
                    dy_r   <= abs_diff(ya_r, yb_r);
                    unpl_r <= (xa_r == UNPLACED) || (ya_r == UNPLACED) ||
                              (xb_r == UNPLACED) || (yb_r == UNPLACED);
                end
                S_ACC: begin
                    edge_addr <= edge_addr + {{(EDGE_AW-1){1'b0}}, 1'b1};
                    if (unpl_r) begin
                        err_unplaced <= err_unplaced + {{EDGE_AW{1'b0}}, 1'b1};
                    end else begin
                        cost_total <= sat_add(cost_total, w_s);
                        cost_hop   <= sat_add(cost_hop, h_s);
                        if (w_s > cost_max) begin
                            cost_max <= w_s;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
